// File: rtl/matvec_seq_pkg.sv
// rtl/matvec_seq_pkg.sv - shared FSM encoding, word-width derivation and saturation limits for matvec_seq
package matvec_seq_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      RUN    = 3'd2,
      STORE  = 3'd3,
      FINISH = 3'd4
   } state_t;

   localparam int DEF_QN = 6;
   localparam int DEF_QM = 11;

   function automatic int calc_bitwidth(input int qn, input int qm);
      return qn + qm + 1;
   endfunction

   // Limits are returned in 64 bits; callers slice them down to their own word width.
   function automatic logic [63:0] sat_max_val(input int w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] sat_min_val(input int w);
      return ~sat_max_val(w);
   endfunction

endpackage

// File: rtl/matvec_seq_sat_add.sv
// rtl/matvec_seq_sat_add.sv - combinational signed saturating adder
module sat_add
   import matvec_seq_pkg::*;
#(
   parameter int W = 18
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W-1:0] y
);

   localparam logic [63:0] MAX_L = sat_max_val(W);
   localparam logic [63:0] MIN_L = sat_min_val(W);

   logic signed [W:0] sum;

   // One guard bit: overflow shows up as disagreement between the two top bits.
   always_comb begin
      sum = {a[W-1], a} + {b[W-1], b};
      if (sum[W] != sum[W-1]) begin
         y = sum[W] ? MIN_L[W-1:0] : MAX_L[W-1:0];
      end else begin
         y = sum[W-1:0];
      end
   end

endmodule

// File: rtl/matvec_seq.sv
// rtl/matvec_seq.sv - sequences one matrix-vector pass: per row fetch bias, run dot product, store saturated sum
module matvec_seq
   import matvec_seq_pkg::*;
#(
   parameter int N_ROWS  = 16,
   parameter int QN      = DEF_QN,
   parameter int QM      = DEF_QM,
   parameter int RD_LAT  = 1,
   parameter int TIMEOUT = 64,
   localparam int BITWIDTH = calc_bitwidth(QN, QM),
   localparam int AW       = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic                       error,
   output logic [AW-1:0]              rowAddr,
   input  logic signed [BITWIDTH-1:0] biasIn,
   output logic                       dpClear,
   input  logic                       dpReady,
   input  logic signed [BITWIDTH-1:0] dpResult,
   output logic                       resWe,
   output logic [AW-1:0]              resAddr,
   output logic signed [BITWIDTH-1:0] resData
);

   localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [AW-1:0]  ROW_LAST   = AW'(N_ROWS - 1);
   localparam logic [1:0]     FETCH_LAST = 2'(RD_LAT - 1);
   localparam logic [WDW-1:0] WD_LAST    = WDW'(TIMEOUT - 1);

   state_t                       state;
   logic [AW-1:0]                row;
   logic [1:0]                   fcnt;
   logic [WDW-1:0]               wd;
   logic signed [BITWIDTH-1:0]   bias_q;
   logic signed [BITWIDTH-1:0]   bias_sel;
   logic signed [BITWIDTH-1:0]   sum_sat;

   // Bias arrives in the first RUN cycle, so a completion in that same cycle uses it directly.
   assign bias_sel = (wd == '0) ? biasIn : bias_q;

   sat_add #(.W(BITWIDTH)) u_sat (
      .a (dpResult),
      .b (bias_sel),
      .y (sum_sat)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         row     <= '0;
         fcnt    <= '0;
         wd      <= '0;
         bias_q  <= '0;
         error   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         resWe   <= 1'b0;
         rowAddr <= '0;
         resAddr <= '0;
         resData <= '0;
         dpClear <= 1'b1;
      end else begin
         done  <= 1'b0;
         resWe <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= FETCH;
                  row     <= '0;
                  rowAddr <= '0;
                  fcnt    <= '0;
                  error   <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            FETCH: begin
               if (fcnt == FETCH_LAST) begin
                  state   <= RUN;
                  dpClear <= 1'b0;
                  wd      <= '0;
               end else begin
                  fcnt <= fcnt + 2'd1;
               end
            end
            RUN: begin
               if (wd == '0) bias_q <= biasIn;
               if (dpReady) begin
                  state   <= STORE;
                  dpClear <= 1'b1;
                  resWe   <= 1'b1;
                  resAddr <= row;
                  resData <= sum_sat;
               end else if (wd == WD_LAST) begin
                  state   <= IDLE;
                  dpClear <= 1'b1;
                  error   <= 1'b1;
                  busy    <= 1'b0;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            STORE: begin
               if (row == ROW_LAST) begin
                  state <= FINISH;
                  done  <= 1'b1;
               end else begin
                  state   <= FETCH;
                  row     <= row + 1'b1;
                  rowAddr <= row + 1'b1;
                  fcnt    <= '0;
               end
            end
            FINISH: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matvec_seq.sv
// tb/tb_matvec_seq.sv - scoreboard bench for matvec_seq with bias-memory and dot-product models
module tb_matvec_seq;

   localparam int N_ROWS  = 4;
   localparam int RD_LAT  = 3;
   localparam int TIMEOUT = 64;
   localparam int BW      = 18;
   localparam int AW      = 2;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [BW-1:0] data;
   } wr_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          busy, done, error, dpClear, resWe;
   logic [AW-1:0] rowAddr, resAddr;
   logic [BW-1:0] biasIn, resData;
   logic          dpReady = 1'b0;
   logic [BW-1:0] dpResult = '0;

   logic [BW-1:0] bias_tbl [N_ROWS];
   logic [BW-1:0] dp_tbl   [N_ROWS];
   logic [AW-1:0] pipe     [RD_LAT];
   int            hang_row = -1;
   int            dcnt = 0;

   wr_t exp_q [$];
   wr_t e;
   int  checks = 0;
   int  failures = 0;
   int  done_cnt = 0;
   int  busy_cycles = 0;
   int  run2_cycles = 0;

   always #5 clk = ~clk;

   matvec_seq #(
      .N_ROWS (N_ROWS),
      .QN     (6),
      .QM     (11),
      .RD_LAT (RD_LAT),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .error   (error),
      .rowAddr (rowAddr),
      .biasIn  (biasIn),
      .dpClear (dpClear),
      .dpReady (dpReady),
      .dpResult(dpResult),
      .resWe   (resWe),
      .resAddr (resAddr),
      .resData (resData)
   );

   // Bias memory with RD_LAT cycles of read latency.
   always @(posedge clk) begin
      pipe[0] <= rowAddr;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign biasIn = bias_tbl[pipe[RD_LAT-1]];

   // Dot-product model: pulses ready in the 7th cycle after dpClear falls unless the row hangs.
   always @(negedge clk) begin
      if (dpClear) begin
         dcnt    = 0;
         dpReady = 1'b0;
      end else begin
         dcnt    = dcnt + 1;
         dpReady = (dcnt == 7) && (int'(rowAddr) != hang_row);
      end
      dpResult = dp_tbl[rowAddr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (busy) busy_cycles++;
      if (done) done_cnt++;
      if (!dpClear && rowAddr == 2'd2) run2_cycles++;
      if (resWe) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write addr=%0d data=0x%0h required=none", resAddr, resData);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(resAddr), 32'(e.addr));
            chk("wr_data", 32'(resData), 32'(e.data));
            chk("wr_dpclear", 32'(dpClear), 32'd1);
         end
      end
   end

   task automatic push_wr(input logic [AW-1:0] a, input logic [BW-1:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      exp_q.push_back(w);
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk({name, "_idle_timeout"}, 32'(busy), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"},    32'(busy),    32'd0);
      chk({tag, "_done"},    32'(done),    32'd0);
      chk({tag, "_error"},   32'(error),   32'd0);
      chk({tag, "_resWe"},   32'(resWe),   32'd0);
      chk({tag, "_rowAddr"}, 32'(rowAddr), 32'd0);
      chk({tag, "_resAddr"}, 32'(resAddr), 32'd0);
      chk({tag, "_resData"}, 32'(resData), 32'd0);
      chk({tag, "_dpClear"}, 32'(dpClear), 32'd1);
   endtask

   task automatic load_linear();
      for (int r = 0; r < N_ROWS; r++) begin
         dp_tbl[r]   = BW'(r * 100);
         bias_tbl[r] = BW'(5);
      end
   endtask

   task automatic push_linear();
      push_wr(2'd0, 18'd5);
      push_wr(2'd1, 18'd105);
      push_wr(2'd2, 18'd205);
      push_wr(2'd3, 18'd305);
   endtask

   int  d0;
   bit  seen;

   initial begin
      reset = 1'b1;
      start = 1'b0;
      load_linear();
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");

      // Pass A: dpResult = row*100, bias 5; 4 rows of 3+7+1 cycles plus FINISH.
      d0 = done_cnt;
      busy_cycles = 0;
      push_linear();
      pulse_start();
      chk("a_busy_rise", 32'(busy), 32'd1);
      wait_idle("a", 200);
      chk("a_done_once", 32'(done_cnt - d0), 32'd1);
      chk("a_busy_cycles", 32'(busy_cycles), 32'd45);
      chk("a_error", 32'(error), 32'd0);
      chk("a_queue_empty", 32'(exp_q.size()), 32'd0);

      // Pass B: saturation at both rails, and per-row biases that expose stale capture.
      dp_tbl[0] = 18'h1FFFF;  bias_tbl[0] = 18'd1;
      dp_tbl[1] = 18'h20000;  bias_tbl[1] = 18'h3FFFF;
      dp_tbl[2] = 18'h1FFFF;  bias_tbl[2] = 18'h3FFFB;
      dp_tbl[3] = 18'd123;    bias_tbl[3] = 18'h3FF38;
      push_wr(2'd0, 18'h1FFFF);
      push_wr(2'd1, 18'h20000);
      push_wr(2'd2, 18'h1FFFA);
      push_wr(2'd3, 18'h3FFB3);
      pulse_start();
      wait_idle("b", 200);
      chk("b_queue_empty", 32'(exp_q.size()), 32'd0);

      // Pass C: row 2 never completes, watchdog expires after 64 RUN cycles.
      load_linear();
      hang_row = 2;
      d0 = done_cnt;
      run2_cycles = 0;
      push_wr(2'd0, 18'd5);
      push_wr(2'd1, 18'd105);
      pulse_start();
      wait_idle("c", 300);
      chk("c_error", 32'(error), 32'd1);
      chk("c_no_done", 32'(done_cnt - d0), 32'd0);
      chk("c_run_cycles", 32'(run2_cycles), 32'd64);
      chk("c_busy", 32'(busy), 32'd0);
      chk("c_queue_empty", 32'(exp_q.size()), 32'd0);
      hang_row = -1;

      // Pass D: start during RUN and during the FINISH cycle must be ignored.
      d0 = done_cnt;
      push_linear();
      pulse_start();
      chk("d_error_cleared", 32'(error), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = !dpClear;
      end
      chk("d_reach_run", 32'(seen), 32'd1);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         seen = done;
      end
      chk("d_reach_finish", 32'(seen), 32'd1);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (3) @(negedge clk);
      chk("d_finish_start_ignored", 32'(busy), 32'd0);
      chk("d_done_once", 32'(done_cnt - d0), 32'd1);
      chk("d_queue_empty", 32'(exp_q.size()), 32'd0);

      // Pass E: reset (with start) during STORE of row 1 aborts cleanly.
      d0 = done_cnt;
      push_wr(2'd0, 18'd5);
      push_wr(2'd1, 18'd105);
      pulse_start();
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = resWe && (resAddr == 2'd1);
      end
      chk("e_reach_store1", 32'(seen), 32'd1);
      reset = 1'b1;
      start = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      check_reset_outputs("e_after_reset");
      repeat (20) @(negedge clk);
      chk("e_no_done", 32'(done_cnt - d0), 32'd0);
      chk("e_queue_empty", 32'(exp_q.size()), 32'd0);

      d0 = done_cnt;
      push_linear();
      pulse_start();
      wait_idle("e2", 200);
      chk("e2_done_once", 32'(done_cnt - d0), 32'd1);
      chk("e2_queue_empty", 32'(exp_q.size()), 32'd0);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
